// File: rtl/arbitro_lock.sv
// arbitro_lock: registered bus-ownership stage behind the arbitro arbiter.
// Define ARBITRO_LOCK_TIMEOUT_EN to bound tenure to MAX_TENURE cycles.
module arbitro_lock #(
  parameter int MAX_TENURE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] grant_num,
  input  logic       available,
  output logic [3:0] owner_grant,
  output logic [1:0] owner_num,
  output logic       busy,
  output logic       timeout,
  output logic [3:0] req_mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] num_nxt;
  logic       busy_nxt;
  logic       owner_req;
  logic       expire;

  assign owner_req = req[owner_num];

`ifdef ARBITRO_LOCK_TIMEOUT_EN
  localparam int CW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tmo_nxt;
  logic [3:0]    mask_nxt;

  assign expire = (cnt == CW'(MAX_TENURE - 1));
`else
  assign expire   = 1'b0;
  assign timeout  = 1'b0;
  assign req_mask = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (available) state_nxt = OWN;
      OWN:     if (!owner_req || expire) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; a request drop outranks expiry.
  always_comb begin
    grant_nxt = owner_grant;
    num_nxt   = owner_num;
    busy_nxt  = busy;
`ifdef ARBITRO_LOCK_TIMEOUT_EN
    cnt_nxt   = cnt;
    tmo_nxt   = 1'b0;
    mask_nxt  = req_mask;
`endif
    unique case (state)
      IDLE: begin
`ifdef ARBITRO_LOCK_TIMEOUT_EN
        cnt_nxt  = '0;
        mask_nxt = 4'b0000;
`endif
        if (available) begin
          num_nxt   = grant_num;
          grant_nxt = 4'b0001 << grant_num;
          busy_nxt  = 1'b1;
        end
      end
      OWN: begin
        if (!owner_req || expire) begin
          busy_nxt  = 1'b0;
          grant_nxt = 4'b0000;
`ifdef ARBITRO_LOCK_TIMEOUT_EN
          if (owner_req) begin
            tmo_nxt  = 1'b1;
            mask_nxt = owner_grant;
          end
`endif
        end else begin
`ifdef ARBITRO_LOCK_TIMEOUT_EN
          cnt_nxt = cnt + 1'b1;
`endif
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        grant_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_grant <= 4'b0000;
      owner_num   <= 2'd0;
      busy        <= 1'b0;
    end else begin
      owner_grant <= grant_nxt;
      owner_num   <= num_nxt;
      busy        <= busy_nxt;
    end
  end

`ifdef ARBITRO_LOCK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      timeout  <= 1'b0;
      req_mask <= 4'b0000;
    end else begin
      cnt      <= cnt_nxt;
      timeout  <= tmo_nxt;
      req_mask <= mask_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_arbitro_lock.sv
// Randomized bench for arbitro_lock against a tenure/cooldown reference model.
// Works with ARBITRO_LOCK_TIMEOUT_EN either defined or not.
module tb_arbitro_lock;

  localparam int MAXT = 8;

`ifdef ARBITRO_LOCK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] grant_num;
  logic       available;
  logic [3:0] owner_grant;
  logic [1:0] owner_num;
  logic       busy;
  logic       timeout;
  logic [3:0] req_mask;

  int checks   = 0;
  int failures = 0;

  // model: owner identity, busy cycles so far, cycles left before a new grant
  bit       m_busy;
  int       m_owner;
  int       m_tenure;
  int       m_cool;
  bit       m_timeout;
  bit [3:0] m_mask;

  int run_dut;
  int run_mdl;
  int max_run;

  arbitro_lock #(.MAX_TENURE(MAXT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant_num  (grant_num),
    .available  (available),
    .owner_grant(owner_grant),
    .owner_num  (owner_num),
    .busy       (busy),
    .timeout    (timeout),
    .req_mask   (req_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_owner = 0; m_tenure = 0;
      m_cool = 0; m_timeout = 0; m_mask = 0;
    end else if (m_busy) begin
      if (!req[m_owner]) begin
        m_busy = 0; m_cool = 1; m_timeout = 0;
      end else if (TMO_EN && m_tenure == MAXT) begin
        m_busy = 0; m_cool = 1; m_timeout = 1;
        m_mask = 4'(1 << m_owner);
      end else begin
        m_tenure++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
      m_timeout = 0;
    end else begin
      m_mask = 0;
      m_timeout = 0;
      if (available) begin
        m_busy = 1; m_owner = int'(grant_num); m_tenure = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, m_busy});
    check({tag, ".grant"}, {4'd0, owner_grant},
          m_busy ? 8'(1 << m_owner) : 8'd0);
    check({tag, ".num"}, {6'd0, owner_num}, 8'(m_owner));
    check({tag, ".tmo"}, {7'd0, timeout}, {7'd0, m_timeout});
    check({tag, ".mask"}, {4'd0, req_mask}, {4'd0, m_mask});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
    run_dut = busy ? run_dut + 1 : 0;
    run_mdl = m_busy ? run_mdl + 1 : 0;
    if (run_dut > max_run) max_run = run_dut;
  endtask

  initial begin
    m_busy = 0; m_owner = 0; m_tenure = 0;
    m_cool = 0; m_timeout = 0; m_mask = 0;
    run_dut = 0; run_mdl = 0; max_run = 0;

    // reset with everything requesting
    rst = 1; req = 4'b1111; grant_num = 2'd3; available = 1;
    @(negedge clk);
    cycle("rst0");
    cycle("rst1");

    // normal ownership and release
    rst = 0; req = 4'b0100; grant_num = 2'd2; available = 1;
    cycle("own");
    check("own_grant", {4'd0, owner_grant}, 8'h04);
    available = 0;
    cycle("own");
    cycle("own");
    cycle("own");
    req = 4'b0000;
    cycle("drop");
    check("drop_busy", {7'd0, busy}, 8'd0);
    check("drop_tmo", {7'd0, timeout}, 8'd0);
    cycle("idle");

    // continuous requester; timeout expected only with the macro on
    req = 4'b0001; grant_num = 2'd0; available = 1;
    cycle("tmo");
    available = 0;
    for (int i = 0; i < 12; i++) cycle("tmo");
    check("tmo_run", 8'(max_run), TMO_EN ? 8'(MAXT) : 8'd13);
    req = 4'b0000;
    cycle("tmo_end");
    cycle("tmo_end");
    cycle("tmo_end");

    // drop on the last tenure cycle, plus grant_num wiggle mid-ownership
    req = 4'b0010; grant_num = 2'd1; available = 1;
    cycle("sim");
    for (int i = 0; i < MAXT - 1; i++) begin
      grant_num = 2'(i);
      cycle("sim");
      check("sim_num", {6'd0, owner_num}, 8'd1);
    end
    req = 4'b0000;
    cycle("sim_drop");
    check("sim_tmo", {7'd0, timeout}, 8'd0);
    check("sim_mask", {4'd0, req_mask}, 8'd0);
    cycle("sim_idle");

    // reset in the third ownership cycle
    req = 4'b1000; grant_num = 2'd3; available = 1;
    cycle("mid");
    cycle("mid");
    cycle("mid");
    rst = 1;
    cycle("mid_rst");
    check("mid_busy", {7'd0, busy}, 8'd0);
    rst = 0; grant_num = 2'd1; req = 4'b0010;
    cycle("mid_new");
    check("mid_new_num", {6'd0, owner_num}, 8'd1);

    // long hold of requester 3
    req = 4'b0000; available = 0;
    cycle("hold_pre");
    cycle("hold_pre");
    cycle("hold_pre");
    req = 4'b1000; grant_num = 2'd3; available = 1;
    for (int i = 0; i < 20; i++) begin
      cycle("hold");
      check("hold_run", 8'(run_dut), 8'(run_mdl));
    end

    // randomized traffic, requests biased high to reach expiry
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 7) != 0);
      grant_num = 2'($urandom_range(0, 3));
      available = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
